// File: rtl/stream_slot_collector.sv
// stream_slot_collector: deposits each non-idle stream word into the next of CHANNELS parallel slots.
// Revision 1.0
`default_nettype none

module stream_slot_collector #(
  parameter int                DATA_W    = 8,
  parameter int                CHANNELS  = 4,
  parameter int                WRAP_MODE = 0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0,
  parameter int                DROP_W    = 8
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         clear_in,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0]          out_valid,
  output logic [$clog2(CHANNELS)-1:0]  wr_ptr_out,
  output logic                         full_out,
  output logic [DROP_W-1:0]            drop_cnt_out
);

  localparam int              PTR_W = $clog2(CHANNELS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t state;

  logic word_present;
  logic at_last;

  assign word_present = (data_in != IDLE_WORD);
  assign at_last      = (wr_ptr_out == LAST);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= EMPTY;
      out_data     <= '0;
      out_valid    <= '0;
      wr_ptr_out   <= '0;
      full_out     <= 1'b0;
      drop_cnt_out <= '0;
    end else if (clear_in) begin
      // Clear wins over a word arriving in the same cycle; that word is not a drop.
      state        <= EMPTY;
      out_data     <= '0;
      out_valid    <= '0;
      wr_ptr_out   <= '0;
      full_out     <= 1'b0;
      drop_cnt_out <= '0;
    end else if (word_present) begin
      if (state == FULL && WRAP_MODE == 0) begin
        if (drop_cnt_out != '1) begin
          drop_cnt_out <= drop_cnt_out + 1'b1;
        end
      end else begin
        out_data[wr_ptr_out*DATA_W +: DATA_W] <= data_in;
        out_valid[wr_ptr_out]                 <= 1'b1;
        // Explicit wrap so non-power-of-2 slot counts never index past the last slot.
        wr_ptr_out <= at_last ? '0 : wr_ptr_out + 1'b1;
        if (at_last || state == FULL) begin
          state    <= FULL;
          full_out <= 1'b1;
        end else begin
          state <= FILLING;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_slot_collector.sv
// tb_stream_slot_collector: directed scoreboard bench for stream_slot_collector.
// Revision 1.0
`default_nettype none

module tb_stream_slot_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data0 = '0, data1 = '0, data2 = '0;
  logic       clear0 = 1'b0, clear1 = 1'b0, clear2 = 1'b0;

  logic [31:0] odata0, odata1;
  logic [23:0] odata2;
  logic [3:0]  ovalid0, ovalid1;
  logic [2:0]  ovalid2;
  logic [1:0]  optr0, optr1, optr2;
  logic        ofull0, ofull1, ofull2;
  logic [7:0]  odrop0, odrop1, odrop2;

  always #5 clk = ~clk;

  stream_slot_collector #(.DATA_W(8), .CHANNELS(4), .WRAP_MODE(0), .IDLE_WORD(8'h00), .DROP_W(8)) dut0 (
    .clk_in(clk), .reset_in(rst), .data_in(data0), .clear_in(clear0),
    .out_data(odata0), .out_valid(ovalid0), .wr_ptr_out(optr0), .full_out(ofull0), .drop_cnt_out(odrop0));

  stream_slot_collector #(.DATA_W(8), .CHANNELS(4), .WRAP_MODE(1), .IDLE_WORD(8'h00), .DROP_W(8)) dut1 (
    .clk_in(clk), .reset_in(rst), .data_in(data1), .clear_in(clear1),
    .out_data(odata1), .out_valid(ovalid1), .wr_ptr_out(optr1), .full_out(ofull1), .drop_cnt_out(odrop1));

  stream_slot_collector #(.DATA_W(8), .CHANNELS(3), .WRAP_MODE(1), .IDLE_WORD(8'h00), .DROP_W(8)) dut2 (
    .clk_in(clk), .reset_in(rst), .data_in(data2), .clear_in(clear2),
    .out_data(odata2), .out_valid(ovalid2), .wr_ptr_out(optr2), .full_out(ofull2), .drop_cnt_out(odrop2));

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [1:0]  ptr;
    logic        full;
    logic [7:0]  drop;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Monitor: compares every pending expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t        e;
        logic [31:0] a_data;
        logic [3:0]  a_valid;
        logic [1:0]  a_ptr;
        logic        a_full;
        logic [7:0]  a_drop;
        e = sb.pop_front();
        case (e.id)
          0:       begin a_data = odata0; a_valid = ovalid0; a_ptr = optr0; a_full = ofull0; a_drop = odrop0; end
          1:       begin a_data = odata1; a_valid = ovalid1; a_ptr = optr1; a_full = ofull1; a_drop = odrop1; end
          default: begin a_data = {8'h00, odata2}; a_valid = {1'b0, ovalid2}; a_ptr = optr2; a_full = ofull2; a_drop = odrop2; end
        endcase
        checks++;
        if (a_data !== e.data || a_valid !== e.valid || a_ptr !== e.ptr ||
            a_full !== e.full || a_drop !== e.drop) begin
          failures++;
          $display("FAIL %s: got data=%h valid=%b ptr=%0d full=%b drop=%h, want data=%h valid=%b ptr=%0d full=%b drop=%h",
                   e.name, a_data, a_valid, a_ptr, a_full, a_drop,
                   e.data, e.valid, e.ptr, e.full, e.drop);
        end
      end
    end
  end

  task automatic expect_out(input int id, input logic [31:0] d, input logic [3:0] v,
                            input logic [1:0] p, input logic f, input logic [7:0] dr, input string nm);
    exp_t e;
    e.id = id; e.data = d; e.valid = v; e.ptr = p; e.full = f; e.drop = dr; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic set_bus(input int id, input logic [7:0] d, input logic c);
    case (id)
      0:       begin data0 = d; clear0 = c; end
      1:       begin data1 = d; clear1 = c; end
      default: begin data2 = d; clear2 = c; end
    endcase
  endtask

  task automatic word(input int id, input logic [7:0] d, input logic c = 1'b0);
    set_bus(id, d, c);
    @(posedge clk);
    #1;
    set_bus(id, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Fill then stop-when-full
    do_reset();
    expect_out(0, 32'h0, 4'b0000, 2'd0, 1'b0, 8'h00, "reset_state");
    word(0, 8'h11);
    word(0, 8'h22);
    expect_out(0, 32'h0000_2211, 4'b0011, 2'd2, 1'b0, 8'h00, "half_fill");
    word(0, 8'h33);
    word(0, 8'h44);
    expect_out(0, 32'h4433_2211, 4'b1111, 2'd0, 1'b1, 8'h00, "full_fill");
    word(0, 8'h55);
    word(0, 8'h00);
    word(0, 8'h66);
    expect_out(0, 32'h4433_2211, 4'b1111, 2'd0, 1'b1, 8'h02, "drop_two");
    for (int i = 0; i < 300; i++) word(0, 8'h5A);
    expect_out(0, 32'h4433_2211, 4'b1111, 2'd0, 1'b1, 8'hFF, "drop_saturate");
    word(0, 8'h99, 1'b1);
    expect_out(0, 32'h0, 4'b0000, 2'd0, 1'b0, 8'h00, "clear_from_full");

    // Ring overwrite
    do_reset();
    for (int i = 1; i <= 6; i++) word(1, 8'(i));
    expect_out(1, 32'h0403_0605, 4'b1111, 2'd2, 1'b1, 8'h00, "wrap_overwrite");

    // Idle words ignored
    do_reset();
    word(0, 8'hA1);
    word(0, 8'h00);
    word(0, 8'h00);
    word(0, 8'hA2);
    expect_out(0, 32'h0000_A2A1, 4'b0011, 2'd2, 1'b0, 8'h00, "idle_skip");

    // Clear with a word present, then held for two cycles
    do_reset();
    word(0, 8'h31);
    word(0, 8'h32);
    word(0, 8'h77, 1'b1);
    expect_out(0, 32'h0, 4'b0000, 2'd0, 1'b0, 8'h00, "clear_discards");
    word(0, 8'h88);
    expect_out(0, 32'h0000_0088, 4'b0001, 2'd1, 1'b0, 8'h00, "after_clear");
    word(0, 8'h41, 1'b1);
    word(0, 8'h42, 1'b1);
    expect_out(0, 32'h0, 4'b0000, 2'd0, 1'b0, 8'h00, "clear_held");
    word(0, 8'h43);
    expect_out(0, 32'h0000_0043, 4'b0001, 2'd1, 1'b0, 8'h00, "resume_after_clear");

    // Asynchronous reset between edges
    do_reset();
    word(0, 8'hB1);
    word(0, 8'hB2);
    word(0, 8'hB3);
    #2;
    rst = 1'b1;
    #1;
    expect_out(0, 32'h0, 4'b0000, 2'd0, 1'b0, 8'h00, "async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    word(0, 8'h10);
    word(0, 8'h20);
    expect_out(0, 32'h0000_2010, 4'b0011, 2'd2, 1'b0, 8'h00, "refill_after_reset");

    // Non-power-of-2 slot count with ring overwrite
    do_reset();
    word(2, 8'h0A);
    word(2, 8'h0B);
    word(2, 8'h0C);
    expect_out(2, 32'h000C_0B0A, 4'b0111, 2'd0, 1'b1, 8'h00, "ch3_full_wrap");
    word(2, 8'h0D);
    word(2, 8'h0E);
    expect_out(2, 32'h000C_0E0D, 4'b0111, 2'd2, 1'b1, 8'h00, "ch3_overwrite");

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
